// File: rtl/pio_pkg.sv
// Shared definitions for the PIO arbiter / keyboard scanner.
// Port selects on {CDSEL,BASEL} and the scan sequencer states.
package pio_pkg;

  localparam logic [1:0] SEL_AD = 2'b00;
  localparam logic [1:0] SEL_BD = 2'b01;
  localparam logic [1:0] SEL_AC = 2'b10;
  localparam logic [1:0] SEL_BC = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WROW,
    S_SETTLE,
    S_RDCOL,
    S_RESTORE
  } scan_state_t;

endpackage

// File: rtl/pio_key_matrix.sv
// Row-indexed key matrix: 16x8 registers, one write port,
// one combinational read port returning FF outside ROWS.
module pio_key_matrix #(
  parameter int ROWS = 10
)(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) >= ROWS) ? 8'hFF : mem[raddr];

endmodule

// File: rtl/pio_scan_arb.sv
// Shares the z8420 PIO bus between the CPU and a keyboard scanner.
// CPU always wins; port A is shadowed and restored after each frame.
module pio_scan_arb
  import pio_pkg::*;
#(
  parameter int ROWS     = 10,
  parameter int SETTLE   = 4,
  parameter int SCAN_GAP = 1000
)(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       ENA,
  input  logic       CPU_CE,
  input  logic       CPU_RD_n,
  input  logic       CPU_WR_n,
  input  logic       CPU_BASEL,
  input  logic       CPU_CDSEL,
  input  logic [7:0] CPU_DI,
  output logic [7:0] CPU_DO,
  output logic       PIO_CE,
  output logic       PIO_RD_n,
  output logic       PIO_WR_n,
  output logic       PIO_BASEL,
  output logic       PIO_CDSEL,
  output logic [7:0] PIO_DI,
  input  logic [7:0] PIO_DO,
  input  logic       SCAN_EN,
  input  logic [3:0] KEY_ROW,
  output logic [7:0] KEY_COL,
  output logic       SCAN_DONE
);

  localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(SCAN_GAP - 1);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE - 1);
  localparam logic [3:0]    ROW_MAX = 4'(ROWS - 1);

  scan_state_t   state;
  logic [GW-1:0] gap;
  logic [SW-1:0] settle;
  logic [3:0]    row;
  logic [7:0]    shadow;
  logic          done;

  logic       cpu_active;
  logic       scan_req;
  logic       grant;
  logic       shadow_we;
  logic       mat_we;
  logic [1:0] scan_sel;
  logic [7:0] scan_di;

  assign cpu_active = ~CPU_CE & (~CPU_RD_n | ~CPU_WR_n);
  assign scan_req   = state inside {S_WROW, S_RDCOL, S_RESTORE};
  assign grant      = ENA & ~cpu_active & scan_req;
  assign shadow_we  = ENA & ~CPU_CE & ~CPU_WR_n &
                      ({CPU_CDSEL, CPU_BASEL} == SEL_AD);
  assign mat_we     = grant & (state == S_RDCOL);

  assign scan_sel = (state == S_RDCOL) ? SEL_BD : SEL_AD;
  assign scan_di  = (state == S_WROW)    ? {shadow[7:4], row} :
                    (state == S_RESTORE) ? shadow : 8'h00;

  assign CPU_DO    = PIO_DO;
  assign SCAN_DONE = done;

  // Address/data stay on the bus while a scanner op is stalled;
  // only the strobes wait for the grant.
  always_comb begin
    PIO_CE    = 1'b1;
    PIO_RD_n  = 1'b1;
    PIO_WR_n  = 1'b1;
    PIO_BASEL = 1'b0;
    PIO_CDSEL = 1'b0;
    PIO_DI    = 8'h00;
    if (cpu_active) begin
      PIO_CE    = CPU_CE;
      PIO_RD_n  = CPU_RD_n;
      PIO_WR_n  = CPU_WR_n;
      PIO_BASEL = CPU_BASEL;
      PIO_CDSEL = CPU_CDSEL;
      PIO_DI    = CPU_DI;
    end else if (scan_req) begin
      {PIO_CDSEL, PIO_BASEL} = scan_sel;
      PIO_DI = scan_di;
      if (ENA) begin
        PIO_CE = 1'b0;
        if (state == S_RDCOL) PIO_RD_n = 1'b0;
        else                  PIO_WR_n = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= S_IDLE;
      gap    <= '0;
      settle <= '0;
      row    <= 4'd0;
      shadow <= 8'h00;
      done   <= 1'b0;
    end else begin
      if (shadow_we) shadow <= CPU_DI;
      if (ENA) begin
        done <= 1'b0;
        unique case (state)
          S_IDLE: begin
            if (gap == GAP_MAX) begin
              if (SCAN_EN) begin
                row   <= 4'd0;
                state <= S_WROW;
              end
            end else begin
              gap <= gap + 1'b1;
            end
          end
          S_WROW: begin
            if (grant) begin
              settle <= '0;
              state  <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle == SET_MAX) state <= S_RDCOL;
            else                   settle <= settle + 1'b1;
          end
          S_RDCOL: begin
            if (grant) begin
              if (row == ROW_MAX || !SCAN_EN) begin
                state <= S_RESTORE;
              end else begin
                row   <= row + 4'd1;
                state <= S_WROW;
              end
            end
          end
          S_RESTORE: begin
            if (grant) begin
              done  <= 1'b1;
              gap   <= '0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  pio_key_matrix #(.ROWS(ROWS)) u_matrix (
    .CLK   (CLK),
    .RST_n (RST_n),
    .we    (mat_we),
    .waddr (row),
    .wdata (PIO_DO),
    .raddr (KEY_ROW),
    .rdata (KEY_COL)
  );

endmodule

// File: tb/tb_pio_scan_arb.sv
// Directed bench for pio_scan_arb with a small PIO port model.
// ROWS=3, SETTLE=2, SCAN_GAP=8.
module tb_pio_scan_arb;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       ENA;
  logic       CPU_CE, CPU_RD_n, CPU_WR_n, CPU_BASEL, CPU_CDSEL;
  logic [7:0] CPU_DI;
  logic [7:0] CPU_DO;
  logic       PIO_CE, PIO_RD_n, PIO_WR_n, PIO_BASEL, PIO_CDSEL;
  logic [7:0] PIO_DI;
  logic [7:0] PIO_DO;
  logic       SCAN_EN;
  logic [3:0] KEY_ROW;
  logic [7:0] KEY_COL;
  logic       SCAN_DONE;

  int n_run  = 0;
  int n_fail = 0;
  int ndone  = 0;
  int n;
  int d0;

  logic [7:0] areg;
  logic [7:0] pat_xor;
  logic [7:0] one8;
  logic [7:0] wlog [$];

  pio_scan_arb #(.ROWS(3), .SETTLE(2), .SCAN_GAP(8)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ENA       (ENA),
    .CPU_CE    (CPU_CE),
    .CPU_RD_n  (CPU_RD_n),
    .CPU_WR_n  (CPU_WR_n),
    .CPU_BASEL (CPU_BASEL),
    .CPU_CDSEL (CPU_CDSEL),
    .CPU_DI    (CPU_DI),
    .CPU_DO    (CPU_DO),
    .PIO_CE    (PIO_CE),
    .PIO_RD_n  (PIO_RD_n),
    .PIO_WR_n  (PIO_WR_n),
    .PIO_BASEL (PIO_BASEL),
    .PIO_CDSEL (PIO_CDSEL),
    .PIO_DI    (PIO_DI),
    .PIO_DO    (PIO_DO),
    .SCAN_EN   (SCAN_EN),
    .KEY_ROW   (KEY_ROW),
    .KEY_COL   (KEY_COL),
    .SCAN_DONE (SCAN_DONE)
  );

  always #5 CLK = ~CLK;

  // PIO model: port B shows ~(1<<AREG[3:0]), optionally xored
  assign one8   = 8'h01;
  assign PIO_DO = ({PIO_CDSEL, PIO_BASEL} == 2'b01) ?
                  (~(one8 << areg[3:0]) ^ pat_xor) : areg;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) areg <= 8'h00;
    else if (ENA && !PIO_CE && !PIO_WR_n &&
             {PIO_CDSEL, PIO_BASEL} == 2'b00)
      areg <= PIO_DI;
  end

  // log port-A writes issued by the scanner
  always @(posedge CLK) begin
    if (RST_n && ENA && CPU_CE && !PIO_CE && !PIO_WR_n &&
        {PIO_CDSEL, PIO_BASEL} == 2'b00)
      wlog.push_back(PIO_DI);
  end

  always @(negedge CLK) if (SCAN_DONE) ndone++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int cnt,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, wlog.size(), cnt);
    for (int i = 0; i < cnt; i++)
      chk($sformatf("%s_%0d", tag, i),
          (i < wlog.size()) ? {24'd0, wlog[i]} : 32'hDEAD, e[i]);
  endtask

  task automatic chk_row(input string tag, input logic [3:0] r,
                         input logic [7:0] exp);
    KEY_ROW = r;
    #1;
    chk(tag, KEY_COL, exp);
  endtask

  task automatic wait_done(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!SCAN_DONE && cnt < lim);
    chk("done_seen", SCAN_DONE, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0; ENA = 1'b1; SCAN_EN = 1'b1; KEY_ROW = 4'd0;
    CPU_CE = 1'b1; CPU_RD_n = 1'b1; CPU_WR_n = 1'b1;
    CPU_BASEL = 1'b0; CPU_CDSEL = 1'b0; CPU_DI = 8'h00;
    pat_xor = 8'h00;

    // reset state
    @(negedge CLK); #1;
    chk("rst_ce", PIO_CE, 1'b1);
    chk("rst_rd", PIO_RD_n, 1'b1);
    chk("rst_wr", PIO_WR_n, 1'b1);
    chk("rst_di", PIO_DI, 8'h00);
    chk("rst_done", SCAN_DONE, 1'b0);
    chk("rst_key0", KEY_COL, 8'hFF);

    // first frame: gap 8 + 3*(2+2)+1 = 21 ticks
    @(negedge CLK); RST_n = 1'b1;
    wait_done(100, n);
    chk("f1_len", n, 21);
    chk_log("f1_wr", 4, 8'h00, 8'h01, 8'h02, 8'h00);
    @(negedge CLK);
    chk("f1_done_pulse", SCAN_DONE, 1'b0);
    chk("f1_ndone", ndone, 1);
    chk_row("f1_row0", 4'd0, 8'hFE);
    chk_row("f1_row1", 4'd1, 8'hFD);
    chk_row("f1_row2", 4'd2, 8'hFB);
    chk_row("f1_row3", 4'd3, 8'hFF);

    // CPU writes A5 to port A before the frame
    @(negedge CLK);
    wlog.delete();
    CPU_CE = 1'b0; CPU_WR_n = 1'b0; CPU_DI = 8'hA5;
    #1;
    chk("cpuwr_di", PIO_DI, 8'hA5);
    chk("cpuwr_wr", PIO_WR_n, 1'b0);
    @(negedge CLK);
    CPU_CE = 1'b1; CPU_WR_n = 1'b1; CPU_DI = 8'h00;
    wait_done(100, n);
    chk_log("f2_wr", 4, 8'hA0, 8'hA1, 8'hA2, 8'hA5);

    // CPU reads port B for 3 ticks while the scanner sits in RDCOL
    pat_xor = 8'h10;
    repeat (11) @(negedge CLK);
    CPU_CE = 1'b0; CPU_RD_n = 1'b0; CPU_BASEL = 1'b1;
    #1;
    chk("stall_sel", {PIO_CDSEL, PIO_BASEL}, 2'b01);
    chk("stall_cpudo", CPU_DO, 8'hEE);
    repeat (3) @(negedge CLK);
    CPU_CE = 1'b1; CPU_RD_n = 1'b1; CPU_BASEL = 1'b0;
    #1;
    chk("stall_scan_ce", PIO_CE, 1'b0);
    chk("stall_scan_rd", PIO_RD_n, 1'b0);
    wait_done(100, n);
    chk("stall_len", n, 10);
    chk_row("f3_row0", 4'd0, 8'hEE);
    chk_row("f3_row1", 4'd1, 8'hED);
    chk_row("f3_row2", 4'd2, 8'hEB);

    // reset asserted while the scanner is in WROW
    pat_xor = 8'h00;
    repeat (8) @(negedge CLK);
    #1;
    chk("wrow_wr", PIO_WR_n, 1'b0);
    chk("wrow_di", PIO_DI, 8'hA0);
    #1;
    RST_n = 1'b0;
    #1;
    chk("arst_ce", PIO_CE, 1'b1);
    chk("arst_wr", PIO_WR_n, 1'b1);
    chk("arst_di", PIO_DI, 8'h00);
    chk("arst_done", SCAN_DONE, 1'b0);
    KEY_ROW = 4'd1;
    #1;
    chk("arst_key1", KEY_COL, 8'hFF);
    @(negedge CLK);
    wlog.delete();
    d0 = ndone;
    RST_n = 1'b1;

    // SCAN_EN dropped during SETTLE of row 1
    repeat (14) @(negedge CLK);
    SCAN_EN = 1'b0;
    wait_done(100, n);
    chk("drop_len", n, 3);
    chk_log("drop_wr", 3, 8'h00, 8'h01, 8'h00, 8'h00);
    repeat (30) @(negedge CLK);
    chk("drop_idle", ndone - d0, 1);
    chk_row("drop_row0", 4'd0, 8'hFE);
    chk_row("drop_row1", 4'd1, 8'hFD);
    chk_row("drop_row2", 4'd2, 8'hFF);

    // CPU writes 3C to port A during SETTLE of row 0
    @(negedge CLK);
    wlog.delete();
    SCAN_EN = 1'b1;
    repeat (2) @(negedge CLK);
    CPU_CE = 1'b0; CPU_WR_n = 1'b0; CPU_DI = 8'h3C;
    @(negedge CLK);
    CPU_CE = 1'b1; CPU_WR_n = 1'b1; CPU_DI = 8'h00;
    wait_done(100, n);
    chk("midwr_len", n, 11);
    chk_log("midwr_wr", 4, 8'h00, 8'h31, 8'h32, 8'h3C);
    chk_row("midwr_row0", 4'd0, 8'hFF);
    chk_row("midwr_row1", 4'd1, 8'hFD);
    chk_row("midwr_row2", 4'd2, 8'hFB);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
